// File: rtl/edge_pulse_tx.sv
// Per-channel event-to-pulse shaper with guaranteed min high/low widths and a saturating pending queue.
// Optional sticky drop flags (ports ovf_clr/overflow) when EDGE_PULSE_TX_OVF_EN is defined.
module edge_pulse_tx #(
  parameter int WIDTH       = 1,
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int CNT_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] event_in,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] busy,
`ifdef EDGE_PULSE_TX_OVF_EN
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] overflow,
`endif
  output logic [WIDTH-1:0] pending_full
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [TW-1:0]        HIGH_INIT = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]        LOW_INIT  = TW'(LOW_CYCLES - 1);
  localparam logic [CNT_DEPTH-1:0] PMAX      = {CNT_DEPTH{1'b1}};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [1:0]           state_reg, state_next;
      logic [TW-1:0]        timer_reg, timer_next;
      logic [CNT_DEPTH-1:0] pending_reg, pending_next;
      logic                 pulse_reg, pulse_next;
      logic                 busy_reg;
      logic                 consume, ev_used, queue, drop;

      always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pulse_next = pulse_reg;
        consume    = 1'b0;
        ev_used    = 1'b0;
        case (state_reg)
          IDLE: begin
            if (event_in[gi] || (pending_reg != '0)) begin
              state_next = HIGH;
              timer_next = HIGH_INIT;
              pulse_next = 1'b1;
              // A queued event goes first; the fresh strobe then joins the queue.
              if (pending_reg != '0) consume = 1'b1;
              else                   ev_used = 1'b1;
            end
          end
          HIGH: begin
            if (timer_reg == '0) begin
              state_next = LOW;
              timer_next = LOW_INIT;
              pulse_next = 1'b0;
            end else begin
              timer_next = timer_reg - 1'b1;
            end
          end
          LOW: begin
            if (timer_reg == '0) begin
              if (pending_reg != '0) begin
                state_next = HIGH;
                timer_next = HIGH_INIT;
                pulse_next = 1'b1;
                consume    = 1'b1;
              end else begin
                state_next = IDLE;
              end
            end else begin
              timer_next = timer_reg - 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            timer_next = '0;
            pulse_next = 1'b0;
          end
        endcase

        queue        = event_in[gi] && !ev_used;
        drop         = queue && !consume && (pending_reg == PMAX);
        pending_next = pending_reg;
        if (queue && !consume && !drop) pending_next = pending_reg + 1'b1;
        else if (consume && !queue)     pending_next = pending_reg - 1'b1;
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state_reg   <= IDLE;
          timer_reg   <= '0;
          pending_reg <= '0;
          pulse_reg   <= 1'b0;
          busy_reg    <= 1'b0;
        end else begin
          state_reg   <= state_next;
          timer_reg   <= timer_next;
          pending_reg <= pending_next;
          pulse_reg   <= pulse_next;
          busy_reg    <= (state_next != IDLE);
        end
      end

      assign pulse_out[gi]    = pulse_reg;
      assign busy[gi]         = busy_reg;
      assign pending_full[gi] = (pending_reg == PMAX);

`ifdef EDGE_PULSE_TX_OVF_EN
      logic ovf_reg;
      // Set has priority so a drop coinciding with a clear is never lost.
      always_ff @(posedge clk) begin
        if (!reset_n)     ovf_reg <= 1'b0;
        else if (drop)    ovf_reg <= 1'b1;
        else if (ovf_clr) ovf_reg <= 1'b0;
      end
      assign overflow[gi] = ovf_reg;
`else
      logic unused_drop;
      assign unused_drop = drop;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_edge_pulse_tx.sv
// Scoreboard bench for edge_pulse_tx: a phase-counter model predicts every output each cycle.
// Build with EDGE_PULSE_TX_OVF_EN defined to also check the overflow flags.
module tb_edge_pulse_tx;
  localparam int W    = 2;
  localparam int HC   = 3;
  localparam int LC   = 2;
  localparam int CD   = 2;
  localparam int PMAX = (1 << CD) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] event_in = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] pulse_out, busy, pending_full, overflow;

  edge_pulse_tx #(.WIDTH(W), .HIGH_CYCLES(HC), .LOW_CYCLES(LC), .CNT_DEPTH(CD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .event_in(event_in),
    .pulse_out(pulse_out),
    .busy(busy),
`ifdef EDGE_PULSE_TX_OVF_EN
    .ovf_clr(ovf_clr),
    .overflow(overflow),
`endif
    .pending_full(pending_full)
  );

`ifndef EDGE_PULSE_TX_OVF_EN
  assign overflow = '0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] b;
    logic [W-1:0] f;
    logic [W-1:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model state: active flag, position within the HC+LC period, pending count, sticky drop.
  bit m_act[W];
  int m_pos[W];
  int m_pend[W];
  bit m_ovf[W];

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic [W-1:0] ev, input logic rst_n, input logic clr);
    for (int c = 0; c < W; c++) begin
      bit start, cons, fed, q, drop;
      start = 0; cons = 0; fed = 0; drop = 0;
      if (!rst_n) begin
        m_act[c] = 0; m_pos[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
        continue;
      end
      if (!m_act[c]) begin
        if (ev[c] || m_pend[c] > 0) begin
          start = 1;
          if (m_pend[c] > 0) cons = 1; else fed = 1;
        end
      end else if (m_pos[c] == HC + LC - 1) begin
        if (m_pend[c] > 0) begin start = 1; cons = 1; end
        else m_act[c] = 0;
      end else begin
        m_pos[c]++;
      end
      if (start) begin m_act[c] = 1; m_pos[c] = 0; end
      q = ev[c] && !fed;
      if (q && !cons) begin
        if (m_pend[c] == PMAX) drop = 1; else m_pend[c]++;
      end else if (cons && !q) begin
        m_pend[c]--;
      end
      if (drop) m_ovf[c] = 1;
      else if (clr) m_ovf[c] = 0;
    end
  endtask

  task automatic step(input logic [W-1:0] ev, input logic rst_n, input logic clr);
    exp_t e, got;
    event_in = ev;
    reset_n  = rst_n;
    ovf_clr  = clr;
    model_step(ev, rst_n, clr);
    for (int c = 0; c < W; c++) begin
      e.p[c] = m_act[c] && (m_pos[c] < HC);
      e.b[c] = m_act[c];
      e.f[c] = (m_pend[c] == PMAX);
      e.o[c] = m_ovf[c];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    got = '{p: pulse_out, b: busy, f: pending_full, o: overflow};
    check_value("pulse_out", 8'(got.p), 8'(e.p));
    check_value("busy", 8'(got.b), 8'(e.b));
    check_value("pending_full", 8'(got.f), 8'(e.f));
`ifdef EDGE_PULSE_TX_OVF_EN
    check_value("overflow", 8'(got.o), 8'(e.o));
`endif
    $display("cyc=%0d ev=%b rst_n=%b clr=%b pulse=%b busy=%b full=%b ovf=%b",
             cyc, ev, rst_n, clr, got.p, got.b, got.f, got.o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(3);
    // Single event
    step(2'b01, 1'b1, 1'b0);
    idle(10);
    // Three back-to-back events
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0);
    idle(18);
    // Held level saturates the queue and drops events
    for (int i = 0; i < 7; i++) step(2'b01, 1'b1, 1'b0);
    idle(30);
    step('0, 1'b1, 1'b1);
    idle(3);
    // Independent channels
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    idle(12);
    // Reset mid-pulse discards the queue
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(15);
    // Event coinciding with a pending-fed LOW->HIGH start
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    idle(3);
    step(2'b01, 1'b1, 1'b0);
    idle(16);
    // Simultaneous drop and clear: set wins
    for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    idle(25);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ev;
      ev = W'($urandom_range(0, 3)) & {W{$urandom_range(0, 2) == 0}};
      step(ev, ($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0));
    end
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
